// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with pending scoreboard and clear engine.
// Define REGFILE_SB_BYPASS_EN to enable write-through forwarding on the read ports.
module regfile_sb #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  localparam int IDX = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IDX-1:0]   dest,
  input  logic [WIDTH-1:0] in,
  input  logic [IDX-1:0]   src_a,
  input  logic [IDX-1:0]   src_b,
  input  logic [IDX-1:0]   sr,
  output logic [WIDTH-1:0] reg_a,
  output logic [WIDTH-1:0] reg_b,
  output logic [WIDTH-1:0] sr_out,
  input  logic             rsv,
  input  logic [IDX-1:0]   rsv_reg,
  output logic             busy_a,
  output logic             busy_b,
  output logic             busy_sr,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [IDX-1:0] LAST = IDX'(NREGS - 1);

  logic [1:0]       state;
  logic [IDX-1:0]   idx;
  logic [WIDTH-1:0] data [NREGS];
  logic [NREGS-1:0] pend;
  logic             open_q;

  assign open_q = (state != CLEAR);

  // Reserve is applied after the write so a new producer keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      pend  <= '0;
      for (int i = 0; i < NREGS; i++)
        data[i] <= '0;
    end else begin
      unique case (state)
        CLEAR: begin
          data[idx] <= '0;
          pend[idx] <= 1'b0;
          idx       <= idx + 1'b1;
          if (idx == LAST)
            state <= DONE;
        end
        DONE: state <= IDLE;
        default: begin
          if (clr_req) begin
            state <= CLEAR;
            idx   <= '0;
          end
        end
      endcase
      if (open_q && load) begin
        data[dest] <= in;
        pend[dest] <= 1'b0;
      end
      if (open_q && rsv)
        pend[rsv_reg] <= 1'b1;
    end
  end

  logic fwd_a;
  logic fwd_b;
  logic fwd_sr;
  logic keep;

`ifdef REGFILE_SB_BYPASS_EN
  assign fwd_a  = load && open_q && (dest == src_a);
  assign fwd_b  = load && open_q && (dest == src_b);
  assign fwd_sr = load && open_q && (dest == sr);
  assign keep   = rsv && (rsv_reg == dest);
`else
  assign fwd_a  = 1'b0;
  assign fwd_b  = 1'b0;
  assign fwd_sr = 1'b0;
  assign keep   = 1'b0;
`endif

  assign reg_a  = fwd_a  ? in : data[src_a];
  assign reg_b  = fwd_b  ? in : data[src_b];
  assign sr_out = fwd_sr ? in : data[sr];

  assign busy_a  = pend[src_a] && !(fwd_a  && !keep);
  assign busy_b  = pend[src_b] && !(fwd_b  && !keep);
  assign busy_sr = pend[sr]    && !(fwd_sr && !keep);

  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised register file for the pipelined LC-3b datapath that generalises the 8x16 file in width and depth. It keeps the two operand read ports and the store-source read port. It adds a per-register pending scoreboard for hazard detection and a sequential clear engine used on pipeline flush and debug reset. It sits in the decode stage: decode reads operands and reserves destinations, and writeback drives the write port.

Parameters:
WIDTH, 16, data width of each register in bits
NREGS, 8, number of registers; must be a power of two and at least 2
IDX, $clog2(NREGS), register index width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous active-low reset
load  in  1  writeback write enable
dest  in  IDX  writeback destination register
in  in  WIDTH  writeback data
src_a  in  IDX  read port A index
src_b  in  IDX  read port B index
sr  in  IDX  store-source read index
reg_a  out  WIDTH  read data A
reg_b  out  WIDTH  read data B
sr_out  out  WIDTH  store-source read data
rsv  in  1  reserve request: mark rsv_reg pending (decode issue)
rsv_reg  in  IDX  register to reserve
busy_a  out  1  src_a has a pending write
busy_b  out  1  src_b has a pending write
busy_sr  out  1  sr has a pending write
clr_req  in  1  start the sequential clear
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (reset_n=0, asynchronous) forces the following state:
  - all registers = 0, all pending bits = 0
  - FSM = IDLE, clear index = 0
  - clr_busy = 0, clr_done = 0
  - read outputs therefore show 0 and busy outputs show 0.
- Reset deassertion is synchronised externally. The block imposes no extra cycle after reset.
- Reads are combinational: reg_a = data[src_a], reg_b = data[src_b], sr_out = data[sr]. They are valid in every FSM state.
- busy_a, busy_b and busy_sr are combinational lookups of the pending bits, subject to the bypass below.
- Write: when load=1 and the FSM is IDLE, data[dest] <= in and pending[dest] <= 0 at the edge. Write latency is 1 cycle; the new value is visible to reads in the next cycle.
- Reserve: when rsv=1 and the FSM is IDLE, pending[rsv_reg] <= 1.
- Write and reserve to the same register in the same cycle: the data is written and pending ends at 1, because the new producer wins.
- Write and reserve to different registers in the same cycle: both take effect.
- Reserving an already-pending register leaves it pending.
- A write to a non-pending register is legal: data is updated and pending stays 0.
- FSM states:
  - IDLE: on clr_req=1, go to CLEAR with index = 0. load and rsv are honoured in that same cycle, and the clear then overwrites their effect.
  - CLEAR: each cycle, data[index] <= 0, pending[index] <= 0, index++. After index = NREGS-1, go to DONE. clr_busy=1. load, rsv and clr_req are ignored.
  - DONE: clr_done=1 for this single cycle, clr_busy=0. Go to IDLE. load and rsv are honoured in DONE.
- A clear takes exactly NREGS cycles in CLEAR plus 1 cycle in DONE.
- The index wraps naturally at NREGS, with no out-of-range access.
- Reset asserted mid-CLEAR aborts the clear immediately. All state returns to the reset values and no clr_done pulse is produced.
- Registered outputs: clr_busy and clr_done, both decoded from the FSM state register.

Optional Feature:
Macro REGFILE_SB_BYPASS_EN.
- Defined: write-through forwarding is enabled. When load=1, the FSM is not CLEAR, and dest equals a read index, the matching read output returns `in` in the same cycle and its busy output is 0, unless rsv=1 with rsv_reg=dest in that cycle.
- Undefined: reads see the old data until the next cycle, and busy stays 1 until the edge that clears pending.

Test Plan:
- Reset then read: reset_n=0 for 2 cycles, then reset_n=1. Require reg_a, reg_b and sr_out = 0 for every index, all busy = 0, clr_busy=0.
- Basic write: load=1, dest=3, in=16'hBEEF. Next cycle src_a=3 gives reg_a=16'hBEEF; reading register 2 still gives 0.
- Scoreboard: rsv=1, rsv_reg=5. Next cycle src_b=5 gives busy_b=1. Then load=1, dest=5, in=16'h1234 together with rsv=1, rsv_reg=5: busy_b stays 1 and reg_b=16'h1234. Then load dest=5 alone: busy_b=0.
- Clear: fill R0-R7 with 16'h0011*i and reserve R2, then pulse clr_req. Require clr_busy=1 for exactly 8 cycles and a load during that window to be ignored. clr_done pulses once on cycle 9. All registers read 0 and all busy bits are 0.
- Reset mid-clear: assert reset_n=0 in the 4th CLEAR cycle. Require immediate zeros, clr_busy=0 asynchronously, and no clr_done after release.
- Bypass (with REGFILE_SB_BYPASS_EN, NREGS=16, WIDTH=32): R9 pending, load=1, dest=9, in=32'hCAFEF00D, src_a=9 in the same cycle. Require reg_a=32'hCAFEF00D and busy_a=0 combinationally. Without the macro, require the old value and busy_a=1.
